// File: rtl/uart_pkg.sv
// Shared UART definitions: default clock/line rates, bit-period derivation,
// receive FSM state encoding and 8N1 frame constants.
// Latency: n/a (definitions only). Backpressure: n/a.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 20000000;
  localparam int BAUD_DEF     = 9600;

  // 8N1 framing
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per bit; half of this gives the offset to mid-bit.
  function automatic int calc_bps_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Receive FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_speed_select.sv
// Mid-bit baud tick generator for the UART receiver.
// Latency: first clk_bps tick BPS_HALF cycles after bps_start rises, then every BPS_CNT cycles.
// Backpressure: none; dropping bps_start zeroes the counter on the next edge.
// Ports: clk, rst (async, active-high), bps_start (counter enable), clk_bps (one-cycle tick).
module uart_rx_speed_select
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bps_start,
  output logic clk_bps
);

  localparam int BPS_CNT  = calc_bps_cnt(CLK_FREQ, BAUD);
  localparam int BPS_HALF = BPS_CNT / 2;
  localparam int CNT_W    = $clog2(BPS_CNT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_TICK = CNT_W'(BPS_HALF - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!bps_start || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Count BPS_HALF-1 is reached BPS_HALF cycles after enable, then once per bit.
  assign clk_bps = bps_start && (cnt == CNT_TICK);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller: mid-bit sampling of rs232_rx, one-cycle FIFO write per good byte.
// Latency: write/flag pulse one cycle after the stop-bit sample (mid stop bit).
// Backpressure: fifo_full sampled at the stop-bit sample; a full FIFO drops the byte and pulses overflow.
// Ports: clk, rst_n (async, active-high despite the name), rs232_rx, fifo_full,
//        rx_data, fifo232_wrreq, rx_busy, frame_err, overflow.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  input  logic       fifo_full,
  output logic [7:0] rx_data,
  output logic       fifo232_wrreq,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overflow
);

  logic                 rx_meta;
  logic                 rxs;
  logic                 rxs_d;
  logic [2:0]           state;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bps_start;
  logic                 clk_bps;

  // Baud counter runs only while a frame is being sampled; BREAK waits on the line, not on time.
  assign bps_start = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

  uart_rx_speed_select #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_speed_select (
    .clk       (clk),
    .rst       (rst_n),
    .bps_start (bps_start),
    .clk_bps   (clk_bps)
  );

  // Two-flop synchroniser plus one delay flop for edge detection; all preset to idle-high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rs232_rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      rx_data       <= '0;
      fifo232_wrreq <= 1'b0;
      rx_busy       <= 1'b0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      fifo232_wrreq <= 1'b0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rxs_d && !rxs) begin
            state   <= ST_START;
            rx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_bps) begin
            if (rxs) begin
              // Line back high at mid start bit: glitch, not a frame.
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
        end
        ST_DATA: begin
          if (clk_bps) begin
            // LSB arrives first, so shift in from the top.
            shreg   <= {rxs, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (clk_bps) begin
            rx_busy <= 1'b0;
            if (rxs) begin
              // Back to IDLE half a bit early so a following start edge is never missed.
              state <= ST_IDLE;
              if (fifo_full) begin
                overflow <= 1'b1;
              end else begin
                fifo232_wrreq <= 1'b1;
                rx_data       <= shreg;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Line must return high before another start edge can count.
          if (rxs) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl with CLK_FREQ=160, BAUD=10 (16 clocks per bit, mid-bit at 8).
// Latency: n/a. Backpressure: fifo_full driven from stimulus.
// A timing model predicts every output each cycle from the line waveform; scenario checks pin literals.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rs232_rx;
  logic       fifo_full;
  logic [7:0] rx_data;
  logic       fifo232_wrreq;
  logic       rx_busy;
  logic       frame_err;
  logic       overflow;

  uart_rx_ctrl #(
    .CLK_FREQ (160),
    .BAUD     (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs232_rx      (rs232_rx),
    .fifo_full     (fifo_full),
    .rx_data       (rx_data),
    .fifo232_wrreq (fifo232_wrreq),
    .rx_busy       (rx_busy),
    .frame_err     (frame_err),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Line seen by the receiver = rs232_rx two cycles late. A frame starts at the cycle T0 where
  // that delayed line first goes low; samples fall at T0+8+16*k (k=0 start, 1..8 data, 9 stop).
  logic       h1 = 1'b1, h2 = 1'b1, m_prev = 1'b1;
  bit         busy_m = 0, brk_m = 0;
  int         t0_m = 0;
  logic [7:0] bits_m = '0;
  logic       e_wr = 0, e_busy = 0, e_ferr = 0, e_ovf = 0;
  logic [7:0] e_data = '0;

  // scenario monitor
  int         wr_cnt, ferr_cnt, ovf_cnt, busy_cyc;
  logic [7:0] wr_q[$];
  int         wr_cyc_q[$];

  always @(negedge clk) begin
    logic m_rxs;
    int   dt;
    int   k;
    if (rst_n) begin
      h1 = 1'b1; h2 = 1'b1; m_prev = 1'b1;
      busy_m = 0; brk_m = 0; bits_m = '0;
      e_wr = 0; e_busy = 0; e_ferr = 0; e_ovf = 0; e_data = '0;
    end
    chk("wrreq", fifo232_wrreq, e_wr);
    chk("rx_data", rx_data, e_data);
    chk("rx_busy", rx_busy, e_busy);
    chk("frame_err", frame_err, e_ferr);
    chk("overflow", overflow, e_ovf);

    if (fifo232_wrreq) begin wr_cnt++; wr_q.push_back(rx_data); wr_cyc_q.push_back(cyc); end
    if (frame_err) ferr_cnt++;
    if (overflow) ovf_cnt++;
    if (rx_busy) busy_cyc++;

    if (!rst_n) begin
      m_rxs = h2; h2 = h1; h1 = rs232_rx;
      e_wr = 0; e_ferr = 0; e_ovf = 0;
      if (brk_m) begin
        if (m_rxs) brk_m = 0;
      end else if (!busy_m) begin
        if (m_prev && !m_rxs) begin
          busy_m = 1; t0_m = cyc; e_busy = 1;
        end
      end else begin
        dt = cyc - t0_m;
        if (dt == 8) begin
          if (m_rxs) begin busy_m = 0; e_busy = 0; end
        end else if (dt > 8 && (dt - 8) % 16 == 0) begin
          k = (dt - 8) / 16;
          if (k <= 8) begin
            bits_m[k-1] = m_rxs;
          end else begin
            busy_m = 0; e_busy = 0;
            if (m_rxs) begin
              if (fifo_full) e_ovf = 1;
              else begin e_wr = 1; e_data = bits_m; end
            end else begin
              e_ferr = 1; brk_m = 1;
            end
          end
        end
      end
      m_prev = m_rxs;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic line(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rs232_rx = v;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int l);
    @(posedge clk); #1;
    l = cyc;
    rs232_rx = 1'b0;
    line(1'b0, 15);
    for (int i = 0; i < 8; i++) line(b[i], 16);
    line(stop, 16);
  endtask

  task automatic clear_mon();
    wr_cnt = 0; ferr_cnt = 0; ovf_cnt = 0; busy_cyc = 0;
    wr_q.delete(); wr_cyc_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int l1, l2;
    logic [7:0] pb;
    rst_n = 1'b1; rs232_rx = 1'b1; fifo_full = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_wrreq", fifo232_wrreq, 1'b0);
    chk("reset_busy", rx_busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    line(1'b1, 10);

    // 1: clean 0x55
    clear_mon();
    send_frame(8'h55, 1'b1, l1);
    line(1'b1, 20);
    chk("t1_wr_cnt", wr_cnt, 1);
    if (wr_cnt > 0) begin
      chk("t1_data", wr_q[0], 8'h55);
      chk("t1_wr_cycle", wr_cyc_q[0], l1 + 155);
    end
    chk("t1_busy_cycles", busy_cyc, 152);
    chk("t1_flags", ferr_cnt + ovf_cnt, 0);

    // 2: back-to-back 0xA3, 0x0F
    clear_mon();
    send_frame(8'hA3, 1'b1, l1);
    send_frame(8'h0F, 1'b1, l2);
    line(1'b1, 20);
    chk("t2_wr_cnt", wr_cnt, 2);
    if (wr_cnt == 2) begin
      chk("t2_first", wr_q[0], 8'hA3);
      chk("t2_second", wr_q[1], 8'h0F);
      chk("t2_spacing", wr_cyc_q[1] - wr_cyc_q[0], 160);
    end

    // 3: 3-cycle glitch
    clear_mon();
    line(1'b0, 3);
    line(1'b1, 30);
    chk("t3_busy_cycles", busy_cyc, 8);
    chk("t3_wr_cnt", wr_cnt, 0);
    chk("t3_ferr", ferr_cnt, 0);

    // 4: framing error, long low, then 0x3C
    clear_mon();
    send_frame(8'hFF, 1'b0, l1);
    line(1'b0, 40);
    line(1'b1, 20);
    send_frame(8'h3C, 1'b1, l2);
    line(1'b1, 20);
    chk("t4_ferr", ferr_cnt, 1);
    chk("t4_busy_cycles", busy_cyc, 304);
    chk("t4_wr_cnt", wr_cnt, 1);
    if (wr_cnt > 0) chk("t4_data", wr_q[0], 8'h3C);

    // 5: overflow on 0x81, then 0x7E
    clear_mon();
    fifo_full = 1'b1;
    send_frame(8'h81, 1'b1, l1);
    line(1'b1, 5);
    fifo_full = 1'b0;
    send_frame(8'h7E, 1'b1, l2);
    line(1'b1, 20);
    chk("t5_ovf", ovf_cnt, 1);
    chk("t5_wr_cnt", wr_cnt, 1);
    if (wr_cnt > 0) chk("t5_data", wr_q[0], 8'h7E);

    // 6: reset after data bit 3 of 0x96, then 0xC5
    clear_mon();
    pb = 8'h96;
    @(posedge clk); #1 rs232_rx = 1'b0;
    line(1'b0, 15);
    for (int i = 0; i < 4; i++) line(pb[i], 16);
    @(posedge clk); #1 rst_n = 1'b1; rs232_rx = 1'b1;
    @(negedge clk);
    chk("t6_rst_data", rx_data, 8'h00);
    chk("t6_rst_busy", rx_busy, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    line(1'b1, 20);
    send_frame(8'hC5, 1'b1, l1);
    line(1'b1, 20);
    chk("t6_wr_cnt", wr_cnt, 1);
    if (wr_cnt > 0) chk("t6_data", wr_q[0], 8'hC5);

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic       stop;
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) begin
        line(1'b0, $urandom_range(1, 5));
        line(1'b1, $urandom_range(10, 20));
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      send_frame(b, stop, l1);
      if (!stop) line(1'b0, $urandom_range(0, 30));
      fifo_full = ($urandom_range(0, 1) == 0);
      line(1'b1, $urandom_range(0, 25));
    end
    line(1'b1, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller, the receive-side counterpart of the existing transmit controller on the RS232 link. Recovers 8N1 frames from the asynchronous rs232_rx line by mid-bit sampling, then pushes each good byte into the receive FIFO through a single-cycle write request. Runs on the 20 MHz system clock. Instantiates its own mid-bit baud tick generator.

Parameters:
CLK_FREQ, 20000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
BPS_CNT, CLK_FREQ/BAUD (2083), derived localparam: clocks per bit
BPS_HALF, BPS_CNT/2 (1041), derived localparam: clocks to mid-bit

Ports:
clk  in  1  system clock, 20 MHz
rst_n  in  1  asynchronous reset, active-high (asserted = 1)
rs232_rx  in  1  serial input, idles high, asynchronous to clk
fifo_full  in  1  receive FIFO full flag
rx_data  out  8  received byte, valid while fifo232_wrreq = 1
fifo232_wrreq  out  1  FIFO write request, one-cycle pulse, active-high
rx_busy  out  1  high from start-edge detect until frame end
frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0
overflow  out  1  one-cycle pulse when a good byte is dropped because fifo_full = 1

Behaviour:
- Reset values: rx_data = 0x00, fifo232_wrreq/rx_busy/frame_err/overflow = 0. State = IDLE, synchroniser flops = 1, baud counter = 0, shift register = 0.
- Synchroniser: rs232_rx passes through 2 flops. Edge detection uses a third flop. All sampling uses the synchronised value rxs.
- T0 = first cycle in which rxs = 0 after rxs = 1 while in IDLE.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on the falling edge of rxs, go to START, set rx_busy = 1, and enable the baud generator with its counter at 0.
- START: sample at T0+BPS_HALF. If rxs = 0, go to DATA. If rxs = 1, this is a false start: return to IDLE and drop rx_busy. No flags are raised.
- DATA: bit i (i = 0..7, LSB first) is sampled at T0+BPS_HALF+(i+1)*BPS_CNT and shifted in. After bit 7, go to STOP.
- STOP: sample at T0+BPS_HALF+9*BPS_CNT (cycle Ts). The response is registered and appears at Ts+1:
  - rxs = 1 and fifo_full = 0: fifo232_wrreq = 1 for exactly one cycle, with rx_data = assembled byte in that same cycle. Go to IDLE.
  - rxs = 1 and fifo_full = 1: overflow = 1 for one cycle, no write, rx_data unchanged. Go to IDLE.
  - rxs = 0: frame_err = 1 for one cycle, no write. Go to BREAK.
- fifo_full is sampled at Ts only.
- BREAK: wait until rxs = 1, then go to IDLE. A low line never triggers a new frame until it has returned high.
- rx_busy falls at Ts+1 in every terminating case.
- Back-to-back frames: after a good stop, IDLE is re-entered at Ts+1, half a bit before the line-level stop end. The next start edge is detected normally, so there is no minimum idle gap.
- rx_data holds its value between writes.
- Baud generator: counter 0..BPS_CNT-1, wraps to 0. It emits a one-cycle tick when count = BPS_HALF-1, relative to enable. Clearing the enable zeroes the counter immediately.
- Reset mid-frame: everything returns to reset values asynchronously and the partial byte is discarded. After release, the FSM waits in IDLE for a fresh falling edge.
- Line held low across the reset release: the synchroniser starts at 1, so the FSM sees a falling edge and enters START. Accepted behaviour.

Decomposition:
- Shared package uart_pkg: CLK_FREQ/BAUD defaults, the BPS_CNT/BPS_HALF derivation function, the FSM state encoding, and the frame constants (8 data bits, 1 stop bit).
- One sub-module, uart_rx_speed_select: baud counter with bps_start input and a mid-bit clk_bps tick output. It mirrors the transmit-side speed select.

Test Plan:
All scenarios use CLK_FREQ = 160 and BAUD = 10, giving BPS_CNT = 16 and BPS_HALF = 8.
1. Send 0x55 with a clean 8N1 frame -> exactly one fifo232_wrreq pulse at Ts+1 with rx_data = 0x55; rx_busy falls at the same cycle; no flags.
2. Send 0xA3 then 0x0F with zero idle between frames -> two wrreq pulses, 0xA3 first then 0x0F, spaced 160 cycles apart.
3. Low glitch of 3 cycles on an idle line -> START aborts at T0+8; no wrreq, no frame_err; rx_busy high for 8 cycles only.
4. Send 0xFF with the stop bit forced 0, hold the line low 40 cycles, release, then send 0x3C -> frame_err pulse once, no write for 0xFF, no false start during the low hold, then wrreq with rx_data = 0x3C.
5. fifo_full = 1 while 0x81 is received, deassert, then send 0x7E -> overflow pulse and no wrreq for 0x81; wrreq with rx_data = 0x7E and no overflow for the second byte.
6. Assert rst_n (= 1) just after data bit 3 of 0x96, release, then send 0xC5 -> all outputs are reset values during reset; no write of a partial byte; next wrreq carries 0xC5.
